// File: rtl/trap_ctrl_pkg.sv
// Shared types for the trap controller: privilege encoding and the trap request payload.
package trap_ctrl_pkg;

  localparam int unsigned EXC_W = 32;

  typedef enum logic [1:0] {
    PRIV_LVL_U = 2'd0,
    PRIV_LVL_S = 2'd1,
    PRIV_LVL_M = 2'd3
  } priv_lvl_e;

  typedef struct packed {
    logic             valid;
    logic [EXC_W-1:0] cause;
    logic [EXC_W-1:0] tval;
  } exc_s;

endpackage

// File: rtl/trap_ctrl.sv
// Trap controller: arbitrates exceptions, mret and machine interrupts at commit,
// drains the pipeline for interrupts, raises the trap to the CSR file and
// redirects fetch to the trap vector or the mret return address.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  priv_lvl_e       priv_lvl_i,
  input  logic            mstatus_mie_i,
  input  logic [XLEN-1:0] mie_i,
  input  logic            meip_i,
  input  logic            msip_i,
  input  logic            mtip_i,
  input  logic            exc_req_i,
  input  logic [XLEN-1:0] exc_cause_i,
  input  logic [XLEN-1:0] exc_tval_i,
  input  logic [XLEN-1:0] exc_pc_i,
  input  logic            mret_req_i,
  input  logic [XLEN-1:0] commit_pc_i,
  input  logic            pipe_empty_i,
  input  logic [XLEN-1:0] tvec_i,
  input  logic [XLEN-1:0] epc_i,
  input  logic            redirect_ready_i,
  output exc_s            exc_o,
  output logic [XLEN-1:0] pc_o,
  output logic            mret_o,
  output logic            halt_commit_o,
  output logic            flush_o,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic [XLEN-1:0] mip_o
);

  localparam int unsigned MEIP_BIT = 11;
  localparam int unsigned MTIP_BIT = 7;
  localparam int unsigned MSIP_BIT = 3;
  localparam int unsigned CODE_W   = EXC_W - 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1,
    TRAP     = 2'd2,
    REDIRECT = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   mip_d;
  logic [XLEN-1:0]   irq_pend;
  logic              irq_take;
  logic [3:0]        irq_code;
  logic [EXC_W-1:0]  irq_cause;
  logic              exc_take;
  logic [EXC_W-1:0]  cap_cause_q, cap_cause_d;
  logic [EXC_W-1:0]  cap_tval_q, cap_tval_d;
  logic [XLEN-1:0]   cap_epc_q, cap_epc_d;
  logic [XLEN-1:0]   tgt_d;
  logic              flush_c;
  logic              mret_c;

  // Pending-bit image of the level interrupt sources
  always_comb begin
    mip_d           = '0;
    mip_d[MEIP_BIT] = meip_i;
    mip_d[MTIP_BIT] = mtip_i;
    mip_d[MSIP_BIT] = msip_i;
  end

  // Interrupt eligibility and fixed priority MEI > MSI > MTI
  always_comb begin
    irq_pend = mip_o & mie_i;
    irq_take = (|irq_pend) && ((priv_lvl_i < PRIV_LVL_M) || mstatus_mie_i);
    if (irq_pend[MEIP_BIT]) begin
      irq_code = 4'd11;
    end else if (irq_pend[MSIP_BIT]) begin
      irq_code = 4'd3;
    end else begin
      irq_code = 4'd7;
    end
    irq_cause = {1'b1, CODE_W'(irq_code)};
  end

  // Next-state, capture and strobe logic
  always_comb begin
    state_d     = state_q;
    cap_cause_d = cap_cause_q;
    cap_tval_d  = cap_tval_q;
    cap_epc_d   = cap_epc_q;
    tgt_d       = redirect_pc_o;
    flush_c     = 1'b0;
    mret_c      = 1'b0;
    exc_take    = exc_req_i && ((state_q == IDLE) || (state_q == DRAIN));

    if (exc_take) begin
      // A synchronous exception wins in IDLE and also abandons a pending interrupt
      flush_c     = 1'b1;
      cap_cause_d = EXC_W'(exc_cause_i);
      cap_tval_d  = EXC_W'(exc_tval_i);
      cap_epc_d   = exc_pc_i;
      state_d     = TRAP;
    end else begin
      case (state_q)
        IDLE: begin
          if (mret_req_i) begin
            mret_c  = 1'b1;
            flush_c = 1'b1;
            tgt_d   = epc_i;
            state_d = REDIRECT;
          end else if (irq_take) begin
            state_d = DRAIN;
          end
        end
        DRAIN: begin
          if (!irq_take) begin
            state_d = IDLE;
          end else if (pipe_empty_i) begin
            cap_cause_d = irq_cause;
            cap_tval_d  = '0;
            cap_epc_d   = commit_pc_i;
            state_d     = TRAP;
          end
        end
        TRAP: begin
          tgt_d   = tvec_i;
          state_d = REDIRECT;
        end
        REDIRECT: begin
          if (redirect_ready_i) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Same-cycle strobes, held low while reset is asserted
  always_comb begin
    flush_o = flush_c && !rst_i;
    mret_o  = mret_c && !rst_i;
  end

  // State, captured trap data and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q          <= IDLE;
      mip_o            <= '0;
      cap_cause_q      <= '0;
      cap_tval_q       <= '0;
      cap_epc_q        <= '0;
      exc_o            <= '0;
      pc_o             <= '0;
      halt_commit_o    <= 1'b0;
      redirect_valid_o <= 1'b0;
      redirect_pc_o    <= '0;
    end else begin
      state_q          <= state_d;
      mip_o            <= mip_d;
      cap_cause_q      <= cap_cause_d;
      cap_tval_q       <= cap_tval_d;
      cap_epc_q        <= cap_epc_d;
      exc_o.valid      <= (state_d == TRAP);
      exc_o.cause      <= (state_d == TRAP) ? cap_cause_d : '0;
      exc_o.tval       <= (state_d == TRAP) ? cap_tval_d : '0;
      pc_o             <= (state_d == TRAP) ? cap_epc_d : '0;
      halt_commit_o    <= (state_d != IDLE);
      redirect_valid_o <= (state_d == REDIRECT);
      redirect_pc_o    <= tgt_d;
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed vector table, hand sequences for interrupt
// drain/masking/withdrawal/reset, then randomized traffic against a reference model.
module tb_trap_ctrl;
  import trap_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  priv_lvl_e   priv;
  logic        mstatus_mie;
  logic [31:0] mie;
  logic        meip, msip, mtip;
  logic        exc_req;
  logic [31:0] exc_cause, exc_tval, exc_pc;
  logic        mret_req;
  logic [31:0] commit_pc;
  logic        pipe_empty;
  logic [31:0] tvec, epc;
  logic        ready;
  exc_s        exc;
  logic [31:0] pc;
  logic        mret;
  logic        halt;
  logic        flush;
  logic        rv;
  logic [31:0] rpc;
  logic [31:0] mip;

  int tests = 0;
  int fails = 0;

  trap_ctrl #(.XLEN(32)) dut (
    .clk_i(clk), .rst_i(rst), .priv_lvl_i(priv), .mstatus_mie_i(mstatus_mie),
    .mie_i(mie), .meip_i(meip), .msip_i(msip), .mtip_i(mtip),
    .exc_req_i(exc_req), .exc_cause_i(exc_cause), .exc_tval_i(exc_tval), .exc_pc_i(exc_pc),
    .mret_req_i(mret_req), .commit_pc_i(commit_pc), .pipe_empty_i(pipe_empty),
    .tvec_i(tvec), .epc_i(epc), .redirect_ready_i(ready),
    .exc_o(exc), .pc_o(pc), .mret_o(mret), .halt_commit_o(halt), .flush_o(flush),
    .redirect_valid_o(rv), .redirect_pc_o(rpc), .mip_o(mip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        exc;
    logic [31:0] cause, tval, pc;
    logic        mret;
    logic [31:0] epc, tvec;
    logic        ready;
    logic        e_flush, e_mret, e_halt, e_excv;
    logic [31:0] e_cause, e_tval, e_pc;
    logic        e_rv;
    logic [31:0] e_rpc;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(input logic x, input logic [31:0] c, input logic [31:0] t,
                              input logic [31:0] p, input logic m, input logic [31:0] ep,
                              input logic [31:0] tv, input logic r, input logic ef,
                              input logic em, input logic eh, input logic ev,
                              input logic [31:0] ec, input logic [31:0] et,
                              input logic [31:0] epc_e, input logic erv,
                              input logic [31:0] erpc);
    vec_t v;
    v.exc = x; v.cause = c; v.tval = t; v.pc = p; v.mret = m; v.epc = ep; v.tvec = tv;
    v.ready = r; v.e_flush = ef; v.e_mret = em; v.e_halt = eh; v.e_excv = ev;
    v.e_cause = ec; v.e_tval = et; v.e_pc = epc_e; v.e_rv = erv; v.e_rpc = erpc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    priv = PRIV_LVL_M; mstatus_mie = 1'b0; mie = '0;
    meip = 1'b0; msip = 1'b0; mtip = 1'b0;
    exc_req = 1'b0; exc_cause = '0; exc_tval = '0; exc_pc = '0;
    mret_req = 1'b0; commit_pc = '0; pipe_empty = 1'b0;
    tvec = '0; epc = '0; ready = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".mip"}, mip, 32'h0);
    chk({tag, ".halt"}, 32'(halt), 32'h0);
    chk({tag, ".flush"}, 32'(flush), 32'h0);
    chk({tag, ".mret"}, 32'(mret), 32'h0);
    chk({tag, ".exc_valid"}, 32'(exc.valid), 32'h0);
    chk({tag, ".exc_cause"}, exc.cause, 32'h0);
    chk({tag, ".pc"}, pc, 32'h0);
    chk({tag, ".rv"}, 32'(rv), 32'h0);
    chk({tag, ".rpc"}, rpc, 32'h0);
  endtask

  // Reference model state (spec-level bookkeeping)
  bit          m_drain, m_trap, m_redir;
  logic [31:0] m_mip, m_cause, m_tval, m_epc, m_tgt;

  initial begin
    clear_inputs();
    rst = 1'b1;

    // Directed per-cycle vectors: exception, exception/mret collision, mret
    vecs[0]  = mk(1, 2, 32'hDEAD, 32'h100, 0, 0, 0, 0,      1, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 0, 32'h80, 0,              0, 0, 1, 1, 2, 32'hDEAD, 32'h100, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0, 32'h80, 0,              0, 0, 1, 0, 0, 0, 0, 1, 32'h80);
    vecs[3]  = mk(1, 9, 9, 9, 0, 0, 0, 0,                   0, 0, 1, 0, 0, 0, 0, 1, 32'h80);
    vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0, 1,                   0, 0, 1, 0, 0, 0, 0, 1, 32'h80);
    vecs[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0,                   0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[6]  = mk(1, 5, 7, 32'h44, 1, 32'h340, 0, 0,        1, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[7]  = mk(0, 0, 0, 0, 0, 0, 32'h90, 0,              0, 0, 1, 1, 5, 7, 32'h44, 0, 0);
    vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0, 1,                   0, 0, 1, 0, 0, 0, 0, 1, 32'h90);
    vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0,                   0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[10] = mk(0, 0, 0, 0, 1, 32'h340, 0, 0,             1, 1, 0, 0, 0, 0, 0, 0, 0);
    vecs[11] = mk(0, 0, 0, 0, 1, 32'h340, 0, 0,             0, 0, 1, 0, 0, 0, 0, 1, 32'h340);
    vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 0,                   0, 0, 1, 0, 0, 0, 0, 1, 32'h340);
    vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 1,                   0, 0, 1, 0, 0, 0, 0, 1, 32'h340);
    vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 0,                   0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset state
    exc_req = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    next();
    rst = 1'b0;
    exc_req = 1'b0;
    @(negedge clk);
    chk("post_reset.halt", 32'(halt), 32'h0);

    for (int i = 0; i < 15; i++) begin
      next();
      exc_req = vecs[i].exc; exc_cause = vecs[i].cause; exc_tval = vecs[i].tval;
      exc_pc = vecs[i].pc; mret_req = vecs[i].mret; epc = vecs[i].epc;
      tvec = vecs[i].tvec; ready = vecs[i].ready;
      @(negedge clk);
      chk($sformatf("vec%0d.flush", i), 32'(flush), 32'(vecs[i].e_flush));
      chk($sformatf("vec%0d.mret", i), 32'(mret), 32'(vecs[i].e_mret));
      chk($sformatf("vec%0d.halt", i), 32'(halt), 32'(vecs[i].e_halt));
      chk($sformatf("vec%0d.exc_valid", i), 32'(exc.valid), 32'(vecs[i].e_excv));
      chk($sformatf("vec%0d.exc_cause", i), exc.cause, vecs[i].e_cause);
      chk($sformatf("vec%0d.exc_tval", i), exc.tval, vecs[i].e_tval);
      chk($sformatf("vec%0d.pc", i), pc, vecs[i].e_pc);
      chk($sformatf("vec%0d.rv", i), 32'(rv), 32'(vecs[i].e_rv));
      if (vecs[i].e_rv) chk($sformatf("vec%0d.rpc", i), rpc, vecs[i].e_rpc);
    end

    // Interrupt with drain: MEI beats MTI, epc from commit_pc
    next(); clear_inputs(); mstatus_mie = 1'b1; mie = 32'h888; mtip = 1'b1; meip = 1'b1;
    @(negedge clk); chk("irq.mip_latency", mip, 32'h0);
    next(); @(negedge clk); chk("irq.mip", mip, 32'h880); chk("irq.idle_halt", 32'(halt), 32'h0);
    for (int k = 0; k < 2; k++) begin
      next(); @(negedge clk); chk($sformatf("irq.drain_halt%0d", k), 32'(halt), 32'h1);
      chk($sformatf("irq.drain_noexc%0d", k), 32'(exc.valid), 32'h0);
    end
    next(); pipe_empty = 1'b1; commit_pc = 32'h200;
    @(negedge clk); chk("irq.drain_halt2", 32'(halt), 32'h1);
    next(); pipe_empty = 1'b0; tvec = 32'h80; mtip = 1'b0; meip = 1'b0;
    @(negedge clk);
    chk("irq.exc_valid", 32'(exc.valid), 32'h1);
    chk("irq.cause", exc.cause, 32'h8000000B);
    chk("irq.tval", exc.tval, 32'h0);
    chk("irq.pc", pc, 32'h200);
    next(); ready = 1'b1; @(negedge clk);
    chk("irq.rv", 32'(rv), 32'h1); chk("irq.rpc", rpc, 32'h80); chk("irq.excv_once", 32'(exc.valid), 32'h0);
    next(); ready = 1'b0; @(negedge clk); chk("irq.back_idle", 32'(halt), 32'h0);

    // Masking: M-mode with mstatus.MIE=0 never drains; U-mode takes MSI
    next(); clear_inputs(); mie = 32'h888; msip = 1'b1;
    for (int k = 0; k < 4; k++) begin
      next(); @(negedge clk); chk($sformatf("mask.m_nohalt%0d", k), 32'(halt), 32'h0);
    end
    next(); priv = PRIV_LVL_U; @(negedge clk); chk("mask.u_idle", 32'(halt), 32'h0);
    next(); pipe_empty = 1'b1; commit_pc = 32'h300; @(negedge clk); chk("mask.u_drain", 32'(halt), 32'h1);
    next(); pipe_empty = 1'b0; msip = 1'b0; tvec = 32'h40; @(negedge clk);
    chk("mask.u_cause", exc.cause, 32'h80000003); chk("mask.u_pc", pc, 32'h300);
    next(); ready = 1'b1; @(negedge clk); chk("mask.u_rpc", rpc, 32'h40);
    next(); ready = 1'b0; priv = PRIV_LVL_M; @(negedge clk); chk("mask.u_done", 32'(halt), 32'h0);

    // Exception during DRAIN overrides the interrupt
    next(); clear_inputs(); mstatus_mie = 1'b1; mie = 32'h888; mtip = 1'b1;
    next(); @(negedge clk); chk("dexc.idle", 32'(halt), 32'h0);
    next(); exc_req = 1'b1; exc_cause = 32'hC; exc_tval = 32'h11; exc_pc = 32'h500;
    @(negedge clk); chk("dexc.halt", 32'(halt), 32'h1); chk("dexc.flush", 32'(flush), 32'h1);
    next(); exc_req = 1'b0; mtip = 1'b0; @(negedge clk);
    chk("dexc.cause", exc.cause, 32'hC); chk("dexc.tval", exc.tval, 32'h11); chk("dexc.pc", pc, 32'h500);
    next(); ready = 1'b1; @(negedge clk); chk("dexc.rv", 32'(rv), 32'h1);
    next(); ready = 1'b0; @(negedge clk); chk("dexc.idle2", 32'(halt), 32'h0);

    // Withdrawal: MTIP drops during DRAIN -> back to IDLE with no trap
    next(); clear_inputs(); mstatus_mie = 1'b1; mie = 32'h888; mtip = 1'b1;
    next(); @(negedge clk);
    next(); mtip = 1'b0; @(negedge clk); chk("wd.drain", 32'(halt), 32'h1);
    next(); @(negedge clk); chk("wd.drain_hold", 32'(halt), 32'h1);
    for (int k = 0; k < 3; k++) begin
      next(); @(negedge clk);
      chk($sformatf("wd.released%0d", k), 32'(halt), 32'h0);
      chk($sformatf("wd.noexc%0d", k), 32'(exc.valid), 32'h0);
    end

    // Asynchronous reset in the middle of REDIRECT
    next(); clear_inputs(); msip = 1'b1; mret_req = 1'b1; epc = 32'h340;
    @(negedge clk); chk("rst.mret", 32'(mret), 32'h1);
    next(); mret_req = 1'b0; @(negedge clk);
    chk("rst.pre_rv", 32'(rv), 32'h1); chk("rst.pre_mip", mip, 32'h8);
    next(); rst = 1'b1; exc_req = 1'b1;
    #1;
    chk_all_zero("rst_async");
    @(negedge clk); chk_all_zero("rst_held");
    next(); rst = 1'b0; exc_req = 1'b0; msip = 1'b0;
    @(negedge clk); chk("rst.after_halt", 32'(halt), 32'h0); chk("rst.after_mip", mip, 32'h0);

    // Randomized traffic against the reference model
    next(); rst = 1'b1; clear_inputs();
    next(); rst = 1'b0;
    m_drain = 0; m_trap = 0; m_redir = 0;
    m_mip = '0; m_cause = '0; m_tval = '0; m_epc = '0; m_tgt = '0;
    for (int n = 0; n < 1500; n++) begin
      logic        idle, take, e_flush, e_mret;
      logic [31:0] en;
      logic [31:0] icause;
      bit          nd, nt, nr;
      next();
      case ($urandom_range(0, 2))
        0: priv = PRIV_LVL_U;
        1: priv = PRIV_LVL_S;
        default: priv = PRIV_LVL_M;
      endcase
      mstatus_mie = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0: mie = 32'h888;
        1: mie = 32'h080;
        2: mie = 32'h008;
        3: mie = 32'h800;
        default: mie = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) meip = ~meip;
      if ($urandom_range(0, 3) == 0) msip = ~msip;
      if ($urandom_range(0, 3) == 0) mtip = ~mtip;
      exc_req = ($urandom_range(0, 7) == 0);
      mret_req = ($urandom_range(0, 7) == 0);
      pipe_empty = ($urandom_range(0, 2) == 0);
      ready = 1'($urandom_range(0, 1));
      exc_cause = $urandom; exc_tval = $urandom; exc_pc = $urandom;
      commit_pc = $urandom; tvec = $urandom; epc = $urandom;
      @(negedge clk);

      idle = !(m_drain || m_trap || m_redir);
      en = m_mip & mie;
      take = (en != 0) && ((int'(priv) < 3) || mstatus_mie);
      icause = en[11] ? 32'h8000000B : (en[3] ? 32'h80000003 : 32'h80000007);
      e_flush = ((idle || m_drain) && exc_req) || (idle && !exc_req && mret_req);
      e_mret = idle && !exc_req && mret_req;

      chk($sformatf("rnd%0d.mip", n), mip, m_mip);
      chk($sformatf("rnd%0d.halt", n), 32'(halt), 32'(!idle));
      chk($sformatf("rnd%0d.flush", n), 32'(flush), 32'(e_flush));
      chk($sformatf("rnd%0d.mret", n), 32'(mret), 32'(e_mret));
      chk($sformatf("rnd%0d.exc_valid", n), 32'(exc.valid), 32'(m_trap));
      if (m_trap) begin
        chk($sformatf("rnd%0d.cause", n), exc.cause, m_cause);
        chk($sformatf("rnd%0d.tval", n), exc.tval, m_tval);
        chk($sformatf("rnd%0d.pc", n), pc, m_epc);
      end
      chk($sformatf("rnd%0d.rv", n), 32'(rv), 32'(m_redir));
      if (m_redir) chk($sformatf("rnd%0d.rpc", n), rpc, m_tgt);

      nd = m_drain; nt = 0; nr = m_redir;
      if ((idle || m_drain) && exc_req) begin
        m_cause = exc_cause; m_tval = exc_tval; m_epc = exc_pc;
        nd = 0; nt = 1;
      end else if (idle && mret_req) begin
        m_tgt = epc; nr = 1;
      end else if (idle && take) begin
        nd = 1;
      end else if (m_drain && !take) begin
        nd = 0;
      end else if (m_drain && pipe_empty) begin
        m_cause = icause; m_tval = 0; m_epc = commit_pc;
        nd = 0; nt = 1;
      end else if (m_trap) begin
        m_tgt = tvec; nr = 1;
      end else if (m_redir && ready) begin
        nr = 0;
      end
      m_drain = nd; m_trap = nt; m_redir = nr;
      m_mip = (32'(meip) << 11) | (32'(mtip) << 7) | (32'(msip) << 3);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; cause MSB is the interrupt flag.
REQ-002 SHALL have ports, in order:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- priv_lvl_i  in  priv_lvl_e  current privilege level.
- mstatus_mie_i  in  1  global M interrupt enable.
- mie_i  in  XLEN  interrupt enable register.
- meip_i, msip_i, mtip_i  in  1 each  level interrupt sources.
- exc_req_i  in  1  synchronous exception at commit.
- exc_cause_i, exc_tval_i, exc_pc_i  in  XLEN each  exception cause, tval, faulting pc.
- mret_req_i  in  1  mret at commit.
- commit_pc_i  in  XLEN  pc of the next instruction to commit.
- pipe_empty_i  in  1  pipeline drained.
- tvec_i, epc_i  in  XLEN  from the CSR file.
- redirect_ready_i  in  1  fetch accepts redirect.
- exc_o  out  exc_s  trap request to the CSR file (valid, cause, tval).
- pc_o  out  XLEN  epc for the trap.
- mret_o  out  1  mret strobe to the CSR file.
- halt_commit_o  out  1  block new commits.
- flush_o  out  1  flush pipeline.
- redirect_valid_o  out  1  redirect request.
- redirect_pc_o  out  XLEN  redirect target.
- mip_o  out  XLEN  pending bits: MEIP=11, MSIP=3, MTIP=7; others 0.

Function
REQ-003 SHALL have FSM states IDLE, DRAIN, TRAP, REDIRECT.
REQ-004 SHALL register mip_o from the sources each cycle (1-cycle latency).
REQ-005 SHALL define irq_take = |(mip_o & mie_i) && (priv_lvl_i < PRIV_LVL_M || mstatus_mie_i).
REQ-006 SHALL resolve interrupt priority MEI > MSI > MTI; cause = {1, code 11/3/7}; tval = 0.
REQ-007 IDLE priority SHALL be exc_req_i > mret_req_i > irq_take.
REQ-008 IDLE + exc_req_i SHALL capture cause/tval/exc_pc_i, pulse flush_o in the same cycle, and go to TRAP.
REQ-009 IDLE + mret_req_i SHALL pulse mret_o and flush_o for one cycle, set target = epc_i, and go to REDIRECT.
REQ-010 IDLE + irq_take SHALL go to DRAIN.
REQ-011 halt_commit_o SHALL be 1 in DRAIN, TRAP and REDIRECT.
REQ-012 DRAIN + exc_req_i SHALL abandon the interrupt and act per REQ-008.
REQ-013 DRAIN + !irq_take (source withdrawn) SHALL return to IDLE with no trap.
REQ-014 DRAIN + pipe_empty_i SHALL capture the highest-priority interrupt at that cycle, with epc = commit_pc_i, and go to TRAP.
REQ-015 TRAP SHALL assert exc_o.valid for exactly one cycle, drive pc_o = captured epc, set target = tvec_i, and go to REDIRECT.
REQ-016 REDIRECT SHALL hold redirect_valid_o=1 and redirect_pc_o stable until redirect_ready_i=1, then return to IDLE.
REQ-017 In REDIRECT and TRAP, exc_req_i, mret_req_i and interrupts SHALL be ignored.
REQ-018 exc_o.valid, mret_o, flush_o and redirect_valid_o SHALL never be asserted outside the states named above.

Reset
REQ-019 rst_i=1 SHALL immediately force IDLE and clear mip_o, exc_o, pc_o, mret_o, halt_commit_o, flush_o, redirect_valid_o, redirect_pc_o and all captured registers to 0, including mid-DRAIN or mid-REDIRECT.
REQ-020 After reset deassertion, the first trap SHALL require a fresh request.

Verification
REQ-021 Exception: IDLE, exc_req_i with cause=2, tval=0xDEAD, pc=0x100, tvec_i=0x80 -> flush_o same cycle; next cycle exc_o={1,2,0xDEAD}, pc_o=0x100; then redirect_pc_o=0x80 held until ready.
REQ-022 Interrupt: M-mode, mstatus_mie=1, mie=0x888, mtip_i and meip_i rise, pipe_empty_i after 3 cycles, commit_pc_i=0x200 -> halt during drain; exc_o.cause=0x8000000B, pc_o=0x200.
REQ-023 Masking: mstatus_mie=0, priv=M, msip_i=1 -> no DRAIN; same stimulus with priv=U -> trap with cause 0x80000003.
REQ-024 Collisions: exc_req_i and mret_req_i in the same IDLE cycle -> exception taken, mret_o=0; exc_req_i during DRAIN -> exception cause used, not the interrupt.
REQ-025 Withdrawal and reset: mtip drops during DRAIN -> back to IDLE, halt released, no exc_o; rst_i pulse during REDIRECT -> all outputs 0 asynchronously.
REQ-026 mret: mret_req_i with epc_i=0x340 -> mret_o one cycle, redirect_pc_o=0x340, redirect_valid held for 2 cycles of ready=0.
